// File: rtl/jt10_adpcma_ctrl.sv
// jt10_adpcma_ctrl: register front-end and slot sequencer for the six-channel
// ADPCM-A address counter. CPU writes are held as per-channel pending updates
// and replayed as single-cycle pulses in the owning channel's time slot.
//
// Ports:
//   rst_n, clk      async active-low reset, single clock
//   cen             clock enable for slot/round advance and all outputs
//   wr, addr, din   CPU write port (sampled every clk, independent of cen)
//   slot            channel 0..5 owning the current outputs
//   addr_in         start or end address for the current slot (0 if none)
//   up_start/up_end addr_in is a new start / end address for slot
//   aon/aoff        key-on / key-off pulse for slot
//   div3            address-increment enable, one round out of every DIV
// Optional (JT10_ADPCMA_FLAGS_EN): done in, flags[5:0] out, irq_n out.
module jt10_adpcma_ctrl #(
  parameter int unsigned DIV = 3
) (
  input  logic        rst_n,
  input  logic        clk,
  input  logic        cen,
  input  logic        wr,
  input  logic [7:0]  addr,
  input  logic [7:0]  din,
`ifdef JT10_ADPCMA_FLAGS_EN
  input  logic        done,
  output logic [5:0]  flags,
  output logic        irq_n,
`endif
  output logic [2:0]  slot,
  output logic [11:0] addr_in,
  output logic        up_start,
  output logic        up_end,
  output logic        aon,
  output logic        aoff,
  output logic        div3
);

  localparam int unsigned NCH = 6;
  localparam int unsigned SW  = 3;
  localparam int unsigned AW  = 12;
  localparam int unsigned RW  = 4;

  logic [RW-1:0]  round, nround;
  logic [SW-1:0]  nslot, ch;
  logic           ch_ok;
  logic           wr_key, wr_lo, wr_st_hi, wr_end_hi;
  logic [7:0]     shadow;
  logic [AW-1:0]  start_addr [NCH];
  logic [AW-1:0]  end_addr   [NCH];
  logic [NCH-1:0] pend_st, pend_end, pend_on, pend_off;
  logic [NCH-1:0] pend_st_n, pend_end_n, pend_on_n, pend_off_n;
  logic           dlv_st, dlv_end;

  // Slot/round sequencing, write decode and pending-bit next state.
  // Delivery clears are applied before write sets so a coincident write wins.
  always_comb begin
    nslot  = (slot == SW'(NCH-1)) ? '0 : slot + SW'(1);
    nround = round;
    if (slot == SW'(NCH-1))
      nround = (round == RW'(DIV-1)) ? '0 : round + RW'(1);

    ch        = addr[2:0];
    ch_ok     = ch < SW'(NCH);
    wr_key    = wr && (addr == 8'h00);
    wr_lo     = wr && ch_ok && ((addr[7:3] == 5'h02) || (addr[7:3] == 5'h04));
    wr_st_hi  = wr && ch_ok && (addr[7:3] == 5'h03);
    wr_end_hi = wr && ch_ok && (addr[7:3] == 5'h05);

    dlv_st  = cen && pend_st[nslot];
    dlv_end = cen && !pend_st[nslot] && pend_end[nslot];

    pend_st_n  = pend_st;
    pend_end_n = pend_end;
    pend_on_n  = pend_on;
    pend_off_n = pend_off;
    if (dlv_st)    pend_st_n[nslot]  = 1'b0;
    if (dlv_end)   pend_end_n[nslot] = 1'b0;
    if (cen) begin
      pend_on_n[nslot]  = 1'b0;
      pend_off_n[nslot] = 1'b0;
    end
    if (wr_st_hi)  pend_st_n[ch]  = 1'b1;
    if (wr_end_hi) pend_end_n[ch] = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      if (wr_key && din[c]) begin
        pend_on_n[c]  = !din[7];
        pend_off_n[c] = din[7];
      end
    end
  end

  // Register file and pending bits, written regardless of cen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= '0;
      pend_st  <= '0;
      pend_end <= '0;
      pend_on  <= '0;
      pend_off <= '0;
      for (int c = 0; c < NCH; c++) begin
        start_addr[c] <= '0;
        end_addr[c]   <= '0;
      end
    end else begin
      pend_st  <= pend_st_n;
      pend_end <= pend_end_n;
      pend_on  <= pend_on_n;
      pend_off <= pend_off_n;
      if (wr_lo)     shadow         <= din;
      if (wr_st_hi)  start_addr[ch] <= {din[3:0], shadow};
      if (wr_end_hi) end_addr[ch]   <= {din[3:0], shadow};
    end
  end

  // Slot outputs: presented for the slot being entered on this cen edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot     <= '0;
      round    <= '0;
      div3     <= (DIV == 1);
      addr_in  <= '0;
      up_start <= 1'b0;
      up_end   <= 1'b0;
      aon      <= 1'b0;
      aoff     <= 1'b0;
    end else if (cen) begin
      slot     <= nslot;
      round    <= nround;
      div3     <= (nround == RW'(DIV-1));
      up_start <= dlv_st;
      up_end   <= dlv_end;
      aon      <= pend_on[nslot];
      aoff     <= pend_off[nslot];
      if (dlv_st)       addr_in <= start_addr[nslot];
      else if (dlv_end) addr_in <= end_addr[nslot];
      else              addr_in <= '0;
    end
  end

`ifdef JT10_ADPCMA_FLAGS_EN
  logic [NCH-1:0] flags_n;

  // End-of-sample flags; 0x1C also carries the ch4 start-high write.
  always_comb begin
    flags_n = flags;
    if (wr && (addr == 8'h1C)) flags_n = flags_n & ~din[NCH-1:0];
    if (cen && done)           flags_n[slot] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= '0;
      irq_n <= 1'b1;
    end else begin
      flags <= flags_n;
      irq_n <= ~|flags_n;
    end
  end
`endif

endmodule

// File: tb/tb_jt10_adpcma_ctrl.sv
// Directed self-checking bench for jt10_adpcma_ctrl (default build, DIV=3).
// Expected slot/div3 come from a cen-edge counter kept by the bench.
module tb_jt10_adpcma_ctrl;

  logic        rst_n, clk, cen, wr;
  logic [7:0]  addr, din;
  logic [2:0]  slot;
  logic [11:0] addr_in;
  logic        up_start, up_end, aon, aoff, div3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  jt10_adpcma_ctrl #(.DIV(3)) dut (
    .rst_n(rst_n), .clk(clk), .cen(cen), .wr(wr), .addr(addr), .din(din),
    .slot(slot), .addr_in(addr_in), .up_start(up_start), .up_end(up_end),
    .aon(aon), .aoff(aoff), .div3(div3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_outs(input string tag, input logic us, input logic ue,
                            input logic on, input logic off, input logic [11:0] a);
    check({tag, ".slot"},     32'(slot),     32'(cyc % 6));
    check({tag, ".div3"},     32'(div3),     32'(((cyc / 6) % 3) == 2));
    check({tag, ".up_start"}, 32'(up_start), 32'(us));
    check({tag, ".up_end"},   32'(up_end),   32'(ue));
    check({tag, ".aon"},      32'(aon),      32'(on));
    check({tag, ".aoff"},     32'(aoff),     32'(off));
    check({tag, ".addr_in"},  32'(addr_in),  32'(a));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (cen) cyc++;
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
    wr = 1'b1; addr = a; din = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic align(input int s);
    while ((cyc % 6) != s) tick();
  endtask

  initial begin
    rst_n = 1'b0; cen = 1'b1; wr = 1'b0; addr = '0; din = '0;
    #23;
    check_outs("reset", 0, 0, 0, 0, 12'h000);
    rst_n = 1'b1;

    // Free-running slot and div3 sequence over two full DIV periods.
    for (int k = 1; k <= 36; k++) begin
      tick();
      check_outs("seq", 0, 0, 0, 0, 12'h000);
    end

    // Start address for ch2 is delivered once, at slot 2 only.
    align(3);
    wr_reg(8'h12, 8'h34);
    wr_reg(8'h1A, 8'h05);
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 3) check_outs("ch2_start", 1, 0, 0, 0, 12'h534);
      else        check_outs("ch2_idle",  0, 0, 0, 0, 12'h000);
    end

    // ch4: start with key-on together, end one round later.
    align(4);
    wr_reg(8'h14, 8'h11);
    wr_reg(8'h1C, 8'h02);
    wr_reg(8'h24, 8'h22);
    wr_reg(8'h2C, 8'h03);
    wr_reg(8'h00, 8'h10);
    for (int t = 1; t <= 13; t++) begin
      tick();
      if (t == 1)      check_outs("ch4_start", 1, 0, 1, 0, 12'h211);
      else if (t == 7) check_outs("ch4_end",   0, 1, 0, 0, 12'h322);
      else             check_outs("ch4_idle",  0, 0, 0, 0, 12'h000);
    end

    // Key-off overrides pending key-on for ch0; ch5 keeps its key-on.
    align(1);
    wr_reg(8'h00, 8'h21);
    wr_reg(8'h00, 8'h81);
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 2)      check_outs("ch5_on",   0, 0, 1, 0, 12'h000);
      else if (t == 3) check_outs("ch0_off",  0, 0, 0, 1, 12'h000);
      else             check_outs("key_idle", 0, 0, 0, 0, 12'h000);
    end

    // Rewrite of ch3 start on its delivery edge: old now, new one round later.
    align(4);
    wr_reg(8'h13, 8'h56);
    wr_reg(8'h1B, 8'h07);
    tick();
    wr_reg(8'h13, 8'h9A);
    check_outs("ch3_pre", 0, 0, 0, 0, 12'h000);
    wr_reg(8'h1B, 8'h0B);
    check_outs("ch3_old", 1, 0, 0, 0, 12'h756);
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 6) check_outs("ch3_new",  1, 0, 0, 0, 12'hB9A);
      else        check_outs("ch3_idle", 0, 0, 0, 0, 12'h000);
    end

    // cen=0 freezes slot and outputs; writes still land.
    align(5);
    wr_reg(8'h00, 8'h02);
    tick();
    check_outs("ch1_on", 0, 0, 1, 0, 12'h000);
    cen = 1'b0;
    wr_reg(8'h00, 8'h04);
    check_outs("freeze", 0, 0, 1, 0, 12'h000);
    for (int t = 1; t <= 9; t++) begin
      tick();
      check_outs("freeze", 0, 0, 1, 0, 12'h000);
    end
    cen = 1'b1;
    tick();
    check_outs("ch2_on", 0, 0, 1, 0, 12'h000);
    tick();
    check_outs("thaw_idle", 0, 0, 0, 0, 12'h000);

    // Async reset mid-operation clears outputs and drops pending updates.
    wr_reg(8'h15, 8'h44);
    wr_reg(8'h1D, 8'h01);
    wr_reg(8'h00, 8'h3F);
    tick();
    check("pre_rst.aon", 32'(aon), 32'd1);
    #2 rst_n = 1'b0;
    #1 cyc = 0;
    check_outs("async_rst", 0, 0, 0, 0, 12'h000);
    #2 rst_n = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      tick();
      check_outs("post_rst", 0, 0, 0, 0, 12'h000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
